// File: rtl/multicycle_ctrl_fsm_pkg.sv
// multicycle_ctrl_fsm_pkg: opcodes, ALU operation codes and controller state encoding
package multicycle_ctrl_fsm_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RW     = 7'b0111011;
    localparam logic [6:0] OP_IW     = 7'b0011011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

endpackage

// File: rtl/multicycle_ctrl_fsm_alu_op_decoder.sv
// multicycle_ctrl_fsm_alu_op_decoder: opcode/func3/func7 -> alu_op, operand select, legality; RV64W_OPS_EN adds word ops
module multicycle_ctrl_fsm_alu_op_decoder
    import multicycle_ctrl_fsm_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic [6:0] func7,
    output logic [3:0] alu_op,
    output logic       alu_src_imm,
`ifdef RV64W_OPS_EN
    output logic       alu_word,
`endif
    output logic       legal
);

    logic       r_type;
    logic       i_type;
    logic [3:0] f3_op;

    // Classify opcode; word variants share the register/immediate ALU rules
    always_comb begin
`ifdef RV64W_OPS_EN
        r_type   = opcode == OP_R || opcode == OP_RW;
        i_type   = opcode == OP_I || opcode == OP_IW;
        alu_word = opcode == OP_RW || opcode == OP_IW;
`else
        r_type   = opcode == OP_R;
        i_type   = opcode == OP_I;
`endif
    end

    // func3 selects the ALU function; func7[5] picks SUB (register form only) or SRA
    always_comb begin
        f3_op = ALU_ADD;
        case (func3)
            3'b000:  f3_op = (r_type && func7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  f3_op = ALU_SLL;
            3'b010:  f3_op = ALU_SLT;
            3'b011:  f3_op = ALU_SLTU;
            3'b100:  f3_op = ALU_XOR;
            3'b101:  f3_op = func7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  f3_op = ALU_OR;
            default: f3_op = ALU_AND;
        endcase
    end

    // Final operation, operand B source and legality per opcode class
    always_comb begin
        alu_op      = (r_type || i_type) ? f3_op : (opcode == OP_BRANCH) ? ALU_SUB : ALU_ADD;
        alu_src_imm = !(r_type || opcode == OP_BRANCH);
        legal       = r_type ? (func7 == F7_BASE || (func7 == F7_ALT && (func3 == 3'b000 || func3 == 3'b101))) :
                      (opcode == OP_BRANCH) ? (func3 == 3'b000 || func3 == 3'b001) :
                      (i_type || opcode == OP_LOAD || opcode == OP_STORE || opcode == OP_LUI || opcode == OP_JAL);
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: RV64 multi-cycle control unit (IDLE/DECODE/EXEC/MEM/WB/TRAP); RV64W_OPS_EN enables word ops and alu_word
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [31:0]      instruction,
    output logic [4:0]       rd,
    output logic [4:0]       rs1,
    output logic [4:0]       rs2,
    output logic [2:0]       func3,
    output logic [3:0]       alu_op,
    output logic             alu_src_imm,
`ifdef RV64W_OPS_EN
    output logic             alu_word,
`endif
    input  logic             alu_zero,
    output logic             mem_req,
    output logic             mem_we,
    input  logic             mem_ack,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             pc_write,
    output logic             illegal,
    output logic             done,
    output logic [CNT_W-1:0] retired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [31:0]   instr_q;
    logic [TW-1:0] tmo;
    logic [6:0]    opcode;
    logic [6:0]    func7;
    logic          legal;
    logic          is_load;
    logic          is_store;
    logic          is_branch;
    logic          timeout;

    assign opcode    = instr_q[6:0];
    assign rd        = instr_q[11:7];
    assign func3     = instr_q[14:12];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign func7     = instr_q[31:25];
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign is_branch = opcode == OP_BRANCH;
    assign timeout   = tmo == TW'(MEM_TIMEOUT - 1);

    multicycle_ctrl_fsm_alu_op_decoder u_dec (
        .opcode      (opcode),
        .func3       (func3),
        .func7       (func7),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
`ifdef RV64W_OPS_EN
        .alu_word    (alu_word),
`endif
        .legal       (legal)
    );

    // State, latched instruction, MEM wait counter and retired count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            instr_q <= '0;
            tmo     <= '0;
            retired <= '0;
        end else begin
            state <= state_nx;
            if (instr_valid && instr_ready)
                instr_q <= instruction;
            tmo <= (state == S_MEM) ? tmo + 1'b1 : '0;
            if (done && state != S_TRAP)
                retired <= retired + 1'b1;
        end
    end

    // Next state and strobes from current state and latched instruction
    always_comb begin
        state_nx    = state;
        instr_ready = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        pc_write    = 1'b0;
        illegal     = 1'b0;
        done        = 1'b0;
        case (state)
            S_IDLE: begin
                instr_ready = 1'b1;
                state_nx    = instr_valid ? S_DECODE : S_IDLE;
            end
            S_DECODE: state_nx = !legal ? S_TRAP : (opcode == OP_LUI || opcode == OP_JAL) ? S_WB : S_EXEC;
            S_EXEC: begin
                pc_write = is_branch && (func3[0] ? !alu_zero : alu_zero);
                done     = is_branch;
                state_nx = (is_load || is_store) ? S_MEM : is_branch ? S_IDLE : S_WB;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                mem_we   = is_store;
                done     = is_store && mem_ack;
                state_nx = mem_ack ? (is_load ? S_WB : S_IDLE) : timeout ? S_TRAP : S_MEM;
            end
            S_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = is_load;
                pc_write   = opcode == OP_JAL;
                done       = 1'b1;
                state_nx   = S_IDLE;
            end
            S_TRAP: begin
                illegal  = 1'b1;
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: directed self-checking bench for multicycle_ctrl_fsm (RV64W_OPS_EN selects word-op expectations)
module tb_multicycle_ctrl_fsm;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_ack = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_ready, alu_src_imm, mem_req, mem_we, reg_write, mem_to_reg, pc_write, illegal, done;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  func3;
    logic [3:0]  alu_op;
    logic [15:0] retired;
`ifdef RV64W_OPS_EN
    logic        alu_word;
`endif

    int n = 0;
    int fails = 0;
    int req_cycles = 0;
    int accepts = 0;
    int start = 0;
    int exp_ret = 0;

    multicycle_ctrl_fsm #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .rd          (rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .func3       (func3),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
`ifdef RV64W_OPS_EN
        .alu_word    (alu_word),
`endif
        .alu_zero    (alu_zero),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .pc_write    (pc_write),
        .illegal     (illegal),
        .done        (done),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    // Count mem_req cycles and handshakes mid-cycle
    always @(negedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
        if (instr_valid && instr_ready) accepts <= accepts + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] w);
        chk("ready_idle", instr_ready, 1);
        instr_valid = 1'b1;
        instruction = w;
        next();
        instr_valid = 1'b0;
        chk("ready_decode", instr_ready, 0);
        chk("decode_quiet", {reg_write, mem_req, pc_write, illegal, done}, 0);
    endtask

    initial begin
        #2;
        chk("rst_ready", instr_ready, 1);
        chk("rst_strobes", {mem_req, mem_we, reg_write, mem_to_reg, pc_write, illegal, done}, 0);
        chk("rst_retired", retired, 0);
        chk("rst_fields", {rd, rs1, rs2, func3, alu_op}, 0);
        next();
        reset = 1'b1;
        next();

        // add x10,x6,x19
        issue(32'h01330533);
        chk("add_rd", rd, 10);
        chk("add_rs1", rs1, 6);
        chk("add_rs2", rs2, 19);
        chk("add_op", alu_op, 0);
        chk("add_imm", alu_src_imm, 0);
        next();
        chk("add_c2_regw", reg_write, 0);
        next();
        chk("add_c3_regw", reg_write, 1);
        chk("add_c3_done", done, 1);
        chk("add_c3_m2r", mem_to_reg, 0);
        next();
        exp_ret = 1;
        chk("add_retired", retired, exp_ret);

        // sub
        issue(32'h41330533);
        chk("sub_op", alu_op, 1);
        next();
        next();
        chk("sub_regw", reg_write, 1);
        next();
        exp_ret = 2;
        chk("sub_retired", retired, exp_ret);

        // bad opcode, then R-type with alternate func7 on SLL
        issue(32'h0000007F);
        next();
        chk("badop_illegal", illegal, 1);
        chk("badop_done", done, 1);
        next();
        chk("badop_ill_off", illegal, 0);
        chk("badop_retired", retired, exp_ret);
        issue(32'h41331533);
        next();
        chk("badf7_illegal", illegal, 1);
        next();

        // ld x5,8(x2) with ack on the sixth MEM cycle
        issue(32'h00813283);
        chk("ld_op", alu_op, 0);
        chk("ld_imm", alu_src_imm, 1);
        start = req_cycles;
        next();
        chk("ld_exec_req", mem_req, 0);
        next();
        for (int k = 0; k < 5; k++) begin
            chk("ld_wait_req", {mem_req, mem_we, done}, 3'b100);
            next();
        end
        mem_ack = 1'b1;
        #1;
        chk("ld_ack_cycle", {mem_req, done}, 2'b10);
        next();
        mem_ack = 1'b0;
        chk("ld_wb", {reg_write, mem_to_reg, done}, 3'b111);
        chk("ld_req_cycles", req_cycles - start, 6);
        next();
        exp_ret = 3;
        chk("ld_retired", retired, exp_ret);

        // sd x7,16(x2) never acked
        issue(32'h00713823);
        start = req_cycles;
        next();
        next();
        chk("sd_we", {mem_req, mem_we}, 2'b11);
        for (int k = 0; k < 40 && !illegal; k++) next();
        chk("sd_tmo_illegal", {illegal, done, mem_req}, 3'b110);
        chk("sd_req_cycles", req_cycles - start, TMO);
        next();
        chk("sd_tmo_ready", instr_ready, 1);
        chk("sd_tmo_retired", retired, exp_ret);

        // same store acked in its first MEM cycle
        issue(32'h00713823);
        next();
        next();
        mem_ack = 1'b1;
        #1;
        chk("sd_ack_done", {mem_req, mem_we, done}, 3'b111);
        next();
        mem_ack = 1'b0;
        exp_ret = 4;
        chk("sd_ack_retired", retired, exp_ret);

        // beq taken, bne not taken, bad branch func3
        alu_zero = 1'b1;
        issue(32'h00208063);
        chk("beq_op", alu_op, 1);
        chk("beq_imm", alu_src_imm, 0);
        next();
        chk("beq_exec", {pc_write, done, reg_write}, 3'b110);
        next();
        exp_ret = 5;
        chk("beq_retired", retired, exp_ret);
        issue(32'h00209063);
        next();
        chk("bne_exec", {pc_write, done}, 2'b01);
        next();
        exp_ret = 6;
        chk("bne_retired", retired, exp_ret);
        alu_zero = 1'b0;
        issue(32'h0020A063);
        next();
        chk("bbad_illegal", illegal, 1);
        next();

        // jal and lui take DECODE->WB
        issue(32'h000000EF);
        next();
        chk("jal_wb", {pc_write, reg_write, done}, 3'b111);
        next();
        issue(32'h123452B7);
        next();
        chk("lui_wb", {pc_write, reg_write, mem_to_reg, done}, 4'b0101);
        next();
        exp_ret = 8;
        chk("lui_retired", retired, exp_ret);

        // reset asserted while waiting in MEM
        issue(32'h00813283);
        next();
        next();
        chk("rstmem_req", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("rstmem_drop", {mem_req, done, instr_ready}, 3'b001);
        chk("rstmem_retired", retired, 0);
        #2;
        reset = 1'b1;
        next();
        chk("rstmem_idle", {instr_ready, mem_req}, 2'b10);
        exp_ret = 0;

        // 64-bit word op (and x10,x31,x31 in word form)
        issue(32'h01FFF53B);
        next();
`ifdef RV64W_OPS_EN
        chk("w_word", alu_word, 1);
        chk("w_exec", {reg_write, illegal}, 0);
        next();
        chk("w_wb", {reg_write, done}, 2'b11);
        exp_ret = 1;
`else
        chk("w_trap", {illegal, done, reg_write}, 3'b110);
`endif
        next();
        chk("w_retired", retired, exp_ret);

        // valid held high across two R-type instructions
        start = accepts;
        instruction = 32'h01330533;
        instr_valid = 1'b1;
        for (int k = 0; k < 7; k++) next();
        instr_valid = 1'b0;
        next();
        chk("b2b_accepts", accepts - start, 2);
        chk("b2b_retired", retired, exp_ret + 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
        $finish;
    end

endmodule
